// File: rtl/fp_lib_pkg.sv
// ---------------------------------------------------------------------------
// fp_lib_pkg
// Shared widths and types for the fp_lib adder and multiplier datapaths.
//   FP_MANT_W : signed two's-complement mantissa width, Q1.(FP_MANT_W-1)
//   FP_EXP_W  : unsigned biased exponent width
//   FP_LSC_W  : width of a leading-sign count, clog2(FP_MANT_W)+1
// ---------------------------------------------------------------------------
package fp_lib_pkg;

  localparam int FP_MANT_W = 16;
  localparam int FP_EXP_W  = 9;
  localparam int FP_LSC_W  = 5;

  typedef logic [FP_MANT_W-1:0] fp_mant_t;
  typedef logic [FP_EXP_W-1:0]  fp_exp_t;
  typedef logic [FP_LSC_W-1:0]  fp_lsc_t;

endpackage : fp_lib_pkg

// File: rtl/fp_lsc_count.sv
// ---------------------------------------------------------------------------
// fp_lsc_count
// Combinational redundant-sign-bit counter for a signed mantissa.
//   m_i       : signed two's-complement mantissa
//   lsc_o     : number of bits below the MSB that repeat the sign bit,
//               i.e. (leading bits equal to m_i[MSB]) - 1, 0..MANT_W-1
//   is_zero_o : m_i is all zeros
// Shared by the adder and multiplier normalizers.
// ---------------------------------------------------------------------------
module fp_lsc_count
  import fp_lib_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int LSC_W  = FP_LSC_W
) (
  input  logic [MANT_W-1:0] m_i,
  output logic [LSC_W-1:0]  lsc_o,
  output logic              is_zero_o
);

  logic found;

  // Scan from just below the sign bit downwards; stop at the first bit
  // that differs from the sign. Zero and all-ones both give MANT_W-1.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    lsc_o = '0;
    found = 1'b0;
    for (int i = MANT_W - 2; i >= 0; i--) begin
      if (!found) begin
        if (m_i[i] != m_i[MANT_W-1]) begin
          found = 1'b1;
        end else begin
          lsc_o = lsc_o + LSC_W'(1);
        end
      end
    end
  end

  assign is_zero_o = (m_i == '0);

endmodule : fp_lsc_count

// File: rtl/fp_add_normalize.sv
// ---------------------------------------------------------------------------
// fp_add_normalize
// Post-addition normalizer: counts redundant sign bits of the signed sum
// mantissa, left-shifts it out and decrements the exponent, never letting
// the exponent go below zero. Two-stage valid/ready pipeline.
//   clk, rst_n     : clock, synchronous active-low reset
//   in_valid/ready : input handshake; in_ready depends combinationally on
//                    out_ready only
//   in_m, in_e     : signed sum mantissa and its exponent
//   out_valid/ready: output handshake; payload held while stalled
//   out_m, out_e   : normalized mantissa and adjusted exponent
//   out_zero       : input mantissa was zero (out_m/out_e forced to 0)
//   out_underflow  : shift was limited by the exponent reaching zero
// ---------------------------------------------------------------------------
module fp_add_normalize
  import fp_lib_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W,
  parameter int LSC_W  = FP_LSC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_m,
  input  logic [EXP_W-1:0]  in_e,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_m,
  output logic [EXP_W-1:0]  out_e,
  output logic              out_zero,
  output logic              out_underflow
);

  // Stage 1 state
  logic              s1_valid_q;
  logic [MANT_W-1:0] m1_q;
  logic [EXP_W-1:0]  e1_q;
  logic [LSC_W-1:0]  lsc1_q;
  logic              zero1_q;

  // Stage 2 (output) state
  logic              s2_valid_q;
  logic [MANT_W-1:0] m2_q;
  logic [EXP_W-1:0]  e2_q;
  logic              zero2_q;
  logic              uf2_q;

  // Stage 2 next-state
  logic [MANT_W-1:0] m2_d;
  logic [EXP_W-1:0]  e2_d;
  logic              zero2_d;
  logic              uf2_d;

  logic [LSC_W-1:0]  lsc_in;
  logic              zero_in;
  logic              s2_adv;
  logic              s1_load;
  logic              s2_load;

  // Handshake: stage 2 can take a new beat when empty or draining this
  // cycle; stage 1 can when empty or moving into stage 2.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  fp_lsc_count #(
    .MANT_W (MANT_W),
    .LSC_W  (LSC_W)
  ) u_lsc (
    .m_i       (in_m),
    .lsc_o     (lsc_in),
    .is_zero_o (zero_in)
  );

  // Valid bits: a bubble enters a stage whenever it advances without new
  // data, so no beat is duplicated and none is lost.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_adv)   s2_valid_q <= s1_valid_q;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid_q, so it needs no
  // reset; only valid bits and the visible outputs are cleared.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      m1_q    <= in_m;
      e1_q    <= in_e;
      lsc1_q  <= lsc_in;
      zero1_q <= zero_in;
    end
  end

  // Stage 2 datapath: clamp the shift at the exponent so it never wraps.
  logic [EXP_W-1:0] lsc_ext;
  logic [EXP_W-1:0] shift;
  logic             limited;

  always_comb begin
    lsc_ext = EXP_W'(lsc1_q);
    limited = lsc_ext > e1_q;
    shift   = limited ? e1_q : lsc_ext;
    m2_d    = m1_q << shift;
    e2_d    = e1_q - shift;
    zero2_d = 1'b0;
    uf2_d   = limited;
    if (zero1_q) begin
      m2_d    = '0;
      e2_d    = '0;
      zero2_d = 1'b1;
      uf2_d   = 1'b0;
    end
  end

  // Output payload is held while stalled; it reloads only with a new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m2_q    <= '0;
      e2_q    <= '0;
      zero2_q <= 1'b0;
      uf2_q   <= 1'b0;
    end else if (s2_load) begin
      m2_q    <= m2_d;
      e2_q    <= e2_d;
      zero2_q <= zero2_d;
      uf2_q   <= uf2_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_m         = m2_q;
  assign out_e         = e2_q;
  assign out_zero      = zero2_q;
  assign out_underflow = uf2_q;

endmodule : fp_add_normalize

// File: tb/tb_fp_add_normalize.sv
// ---------------------------------------------------------------------------
// tb_fp_add_normalize
// Directed self-checking bench for fp_add_normalize. Inputs change 1ns after
// the rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_fp_add_normalize;
  import fp_lib_pkg::*;

  typedef struct {
    logic [15:0] m;
    logic [8:0]  e;
    logic [15:0] em;
    logic [8:0]  ee;
    logic        ez;
    logic        eu;
  } vec_t;

  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_m;
  logic [8:0]  in_e;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_m;
  logic [8:0]  out_e;
  logic        out_zero;
  logic        out_underflow;

  int errors = 0;
  int checks = 0;
  vec_t vecs [NV];

  fp_add_normalize dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_m          (in_m),
    .in_e          (in_e),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_m         (out_m),
    .out_e         (out_e),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed vectors: {in_m, in_e, out_m, out_e, zero, underflow}
  task automatic load_vectors();
    vecs[0]  = '{16'h0001,  9'd20, 16'h4000,   9'd6, 1'b0, 1'b0}; // lsc 14
    vecs[1]  = '{16'hFFFF, 9'd100, 16'h8000,  9'd85, 1'b0, 1'b0}; // lsc 15
    vecs[2]  = '{16'h4000,   9'd7, 16'h4000,   9'd7, 1'b0, 1'b0}; // normalized
    vecs[3]  = '{16'h0003,   9'd5, 16'h0060,   9'd0, 1'b0, 1'b1}; // lsc 13 > 5
    vecs[4]  = '{16'h0000,  9'd50, 16'h0000,   9'd0, 1'b1, 1'b0}; // zero
    vecs[5]  = '{16'h8000,   9'd3, 16'h8000,   9'd3, 1'b0, 1'b0}; // lsc 0
    vecs[6]  = '{16'h1234,   9'd0, 16'h1234,   9'd0, 1'b0, 1'b1}; // e=0, lsc 2
    vecs[7]  = '{16'hBFFF,   9'd0, 16'hBFFF,   9'd0, 1'b0, 1'b0}; // e=0, lsc 0
    vecs[8]  = '{16'hFFF0,   9'd2, 16'hFFC0,   9'd0, 1'b0, 1'b1}; // lsc 11 > 2
    vecs[9]  = '{16'h00FF, 9'd300, 16'h7F80, 9'd293, 1'b0, 1'b0}; // lsc 7
    vecs[10] = '{16'hE000,   9'd9, 16'h8000,   9'd7, 1'b0, 1'b0}; // lsc 2
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_m      = '0;
    in_e      = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({out_m, out_e, out_zero, out_underflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got m=%h e=%0d z=%b u=%b want all 0",
               out_m, out_e, out_zero, out_underflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Isolated beats: checks two-edge latency and the payload of each vector.
  task automatic test_normalize();
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_m     = vecs[i].m;
      in_e     = vecs[i].e;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL norm_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL norm_latency_early[%0d]: out_valid got %b want 0", i, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_m !== vecs[i].em || out_e !== vecs[i].ee ||
          out_zero !== vecs[i].ez || out_underflow !== vecs[i].eu) begin
        errors++;
        $display("FAIL norm[%0d]: got v=%b m=%h e=%0d z=%b u=%b want v=1 m=%h e=%0d z=%b u=%b",
                 i, out_valid, out_m, out_e, out_zero, out_underflow,
                 vecs[i].em, vecs[i].ee, vecs[i].ez, vecs[i].eu);
      end
      step();
    end
  endtask

  // Full-rate stream with out_ready=1: every vector on consecutive cycles.
  task automatic test_back_to_back();
    int idx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < NV + 4; cyc++) begin
      if (cyc < NV) begin
        in_valid = 1'b1;
        in_m     = vecs[cyc].m;
        in_e     = vecs[cyc].e;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid === 1'b1) begin
        checks++;
        if (idx >= NV) begin
          errors++;
          $display("FAIL b2b_extra_beat: got m=%h want no beat", out_m);
        end else if (out_m !== vecs[idx].em || out_e !== vecs[idx].ee ||
                     out_zero !== vecs[idx].ez || out_underflow !== vecs[idx].eu) begin
          errors++;
          $display("FAIL b2b[%0d]: got m=%h e=%0d z=%b u=%b want m=%h e=%0d z=%b u=%b",
                   idx, out_m, out_e, out_zero, out_underflow,
                   vecs[idx].em, vecs[idx].ee, vecs[idx].ez, vecs[idx].eu);
        end
        idx++;
      end
    end
    checks++;
    if (idx != NV) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats want %0d", idx, NV);
    end
  endtask

  // Beats 0,1,2 pushed while the sink stalls for 4 cycles.
  task automatic test_backpressure();
    int got = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_m = vecs[0].m; in_e = vecs[0].e;
    step();                                  // beat 0 into stage 1
    in_m = vecs[1].m; in_e = vecs[1].e;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_beat2: got %b want 1", in_ready);
    end
    step();                                  // beat 0 -> stage 2, beat 1 in
    in_m = vecs[2].m; in_e = vecs[2].e;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_m !== vecs[0].em || out_e !== vecs[0].ee) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b m=%h e=%0d want v=1 m=%h e=%0d",
                 c, out_valid, out_m, out_e, vecs[0].em, vecs[0].ee);
      end
      if (c < 3) step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: got %b want 1", in_ready);
    end
    // Beat 0 is presented now; beats 1 and 2 must follow on the next edges.
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 3) begin
          errors++;
          $display("FAIL bp_extra_beat: got m=%h want no beat", out_m);
        end else if (out_m !== vecs[got].em || out_e !== vecs[got].ee) begin
          errors++;
          $display("FAIL bp_order[%0d]: got m=%h e=%0d want m=%h e=%0d",
                   got, out_m, out_e, vecs[got].em, vecs[got].ee);
        end
        got++;
      end else if (got > 0 && got < 3) begin
        checks++;
        errors++;
        $display("FAIL bp_gap[%0d]: got out_valid=0 want 1", got);
      end
      step();
      in_valid = 1'b0;
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d beats want 3", got);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_m = vecs[1].m; in_e = vecs[1].e;
    step();
    in_m = vecs[3].m; in_e = vecs[3].e;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_preload: out_valid got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || {out_m, out_e, out_zero, out_underflow} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b m=%h e=%0d z=%b u=%b want all 0",
               out_valid, out_m, out_e, out_zero, out_underflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale[%0d]: got out_valid=%b m=%h want 0", c, out_valid, out_m);
      end
    end
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_normalize();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_fp_add_normalize
